// File: rtl/cls_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder.
//   - default geometry (WIDTH/BLOCK/STAGES)
//   - slice_w(): bits resolved per pipeline stage
//   - cfg_ok():  geometry legality (WIDTH must split into whole blocks per stage)
// The stage-payload struct {a_rem, b_rem, sum_lo, carry, msb_cin, valid} depends on
// WIDTH, so it is declared inside cls_pipe_adder where that parameter is known.
package cls_pipe_adder_pkg;

  localparam int CLS_WIDTH_DEF  = 32;
  localparam int CLS_BLOCK_DEF  = 4;
  localparam int CLS_STAGES_DEF = 2;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int block, input int stages);
    return (stages >= 1) && (block >= 1) && ((width % (block * stages)) == 0);
  endfunction

endpackage

// File: rtl/cls_select_block.sv
// One carry-select block: adds a BLOCK-bit slice for both carry hypotheses in
// parallel and picks the result with the real incoming carry.
// Ports:
//   a, b     in   BLOCK  operand slices (b already inverted for subtract)
//   cin      in   1      carry into this block (selects the hypothesis)
//   sum      out  BLOCK  selected slice sum
//   cout     out  1      carry out of the block
//   msb_cin  out  1      carry into the block's top bit (for signed overflow)
module cls_select_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [BLOCK:0] r0;
  logic [BLOCK:0] r1;

  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  assign sum  = cin ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
  assign cout = cin ? r1[BLOCK]     : r0[BLOCK];

  // sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
  assign msb_cin = sum[BLOCK-1] ^ a[BLOCK-1] ^ b[BLOCK-1];

endmodule

// File: rtl/cls_pipe_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Stage k resolves bits [(k+1)*W/S-1 : k*W/S] using the carry registered by
// stage k-1; the operands travel down the pipe with the partial sum (skewed).
// Flow control is bubble-collapsing: a stage may load whenever it is empty or
// the stage after it is moving.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, carry_in, sub sampled on accept)
//   out_valid/out_ready result handshake (sum, carry_out, overflow)
//   sub                 1: a - b (b inverted, carry forced 1, carry_in ignored)
//   carry_out           carry out of MSB (sub: 1 = no borrow)
//   overflow            signed overflow (carry into MSB ^ carry out of MSB)
module cls_pipe_adder
  import cls_pipe_adder_pkg::*;
#(
  parameter int WIDTH  = CLS_WIDTH_DEF,
  parameter int BLOCK  = CLS_BLOCK_DEF,
  parameter int STAGES = CLS_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SW = slice_w(WIDTH, STAGES);
  localparam int NB = SW / BLOCK;

  if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_err
    $error("cls_pipe_adder: WIDTH must be a multiple of BLOCK*STAGES");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_lo;
    logic             carry;
    logic             msb_cin;
    logic             valid;
  } stage_t;

  stage_t              in_st;
  stage_t              last;
  logic [STAGES-1:0]   v;
  logic [STAGES:0]     rdy;

  // Subtract folds into the add: invert b once here and force the carry.
  always_comb begin
    in_st       = '0;
    in_st.valid = in_valid;
    in_st.a_rem = a;
    in_st.b_rem = sub ? ~b : b;
    in_st.carry = sub | carry_in;
  end

  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~v[k] | rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t        src;
    stage_t        st_d;
    stage_t        st_q;
    logic [NB:0]   c;
    logic [SW-1:0] s;
    logic [NB-1:0] mc;
    logic          unused_mc;

    if (k == 0) begin : g_first
      assign src = in_st;
    end else begin : g_next
      assign src = g_st[k-1].st_q;
    end

    // Blocks inside a stage chain through their selects, not through adders.
    assign c[0] = src.carry;
    for (genvar j = 0; j < NB; j++) begin : g_blk
      cls_select_block #(.BLOCK(BLOCK)) u_blk (
        .a       (src.a_rem[k*SW + j*BLOCK +: BLOCK]),
        .b       (src.b_rem[k*SW + j*BLOCK +: BLOCK]),
        .cin     (c[j]),
        .sum     (s[j*BLOCK +: BLOCK]),
        .cout    (c[j+1]),
        .msb_cin (mc[j])
      );
    end

    // Only the top block's MSB carry matters; in the last stage it is the word MSB.
    assign unused_mc = ^mc;

    always_comb begin
      st_d                   = src;
      st_d.sum_lo[k*SW +: SW] = s;
      st_d.carry             = c[NB];
      st_d.msb_cin           = mc[NB-1];
    end

    // Data only updates on a real transfer, so a drained pipe keeps the last result.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q <= '0;
      end else if (rdy[k]) begin
        if (src.valid) st_q <= st_d;
        else           st_q.valid <= 1'b0;
      end
    end

    assign v[k] = st_q.valid;
  end

  assign last = g_st[STAGES-1].st_q;

  logic unused_rem;
  assign unused_rem = ^{last.a_rem, last.b_rem};

  assign out_valid = last.valid;
  assign sum       = last.sum_lo;
  assign carry_out = last.carry;
  assign overflow  = last.carry ^ last.msb_cin;

endmodule
